// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, arbiter FSM states and op-support check
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_JMP  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SGT  = 4'd11;
  localparam logic [3:0] ALU_CLZO = 4'd12;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  function automatic logic alu_op_supported(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SUB, ALU_SLT,
                      ALU_JMP, ALU_MUL, ALU_SLL, ALU_SGT, ALU_CLZO};
  endfunction
endpackage

// File: rtl/ALU32Bit.sv
// ALU32Bit: combinational 32-bit ALU selected by ALUControl
module ALU32Bit (
  input  logic [3:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUResult,
  output logic        Zero
);
  logic [5:0] cnt;
  logic       stop;
  // count leading bits of A equal to B[0] (CLZ when 0, CLO when 1)
  always_comb begin
    cnt = '0;
    stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      stop = stop | (A[i] != B[0]);
      cnt = cnt + 6'(!stop);
    end
  end
  // operation select; unimplemented codes give 0
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      4'd0:  ALUResult = A & B;
      4'd1:  ALUResult = A | B;
      4'd2:  ALUResult = A + B;
      4'd3:  ALUResult = ~(A | B);
      4'd6:  ALUResult = A - B;
      4'd7:  ALUResult = {31'd0, $signed(A) < $signed(B)};
      4'd8:  ALUResult = '0;
      4'd9:  ALUResult = A * B;
      4'd10: ALUResult = A << B[10:6];
      4'd11: ALUResult = {31'd0, $signed(A) > $signed(B)};
      4'd12: ALUResult = {26'd0, cnt};
      default: ALUResult = '0;
    endcase
  end
  assign Zero = ALUResult == '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting one past the last granted index
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  logic [IDXW-1:0] c;
  // scan last_grant+1 .. last_grant+NREQ (wrapping), first requester wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int i = 1; i <= NREQ; i++) begin
      c = IDXW'((int'(last_grant) + i) % NREQ);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end
  assign gnt = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU32Bit among NREQ requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*4-1:0]  req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);
  state_t          state, nstate;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] widx, gidx, last;
  logic            any, accept, done, sup, unused_alu_zero;
  logic [3:0]      op_q;
  logic [31:0]     a_q, b_q, alu_res;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req(req_valid), .last_grant(last), .gnt(gnt), .idx(widx), .any(any)
  );

  ALU32Bit u_alu (
    .ALUControl(op_q), .A(a_q), .B(b_q), .ALUResult(alu_res), .Zero(unused_alu_zero)
  );

  assign req_ready = (state == S_IDLE && Rst) ? gnt : '0;
  assign accept    = state == S_IDLE && any;
  assign done      = state == S_RESP && |(rsp_valid & rsp_ready);
  assign sup       = alu_op_supported(op_q);
  assign busy      = state != S_IDLE;

  // state register
  always_ff @(posedge Clk) state <= !Rst ? S_IDLE : nstate;

  // next state: accept -> one exec cycle -> hold until the owner takes the response
  always_comb begin
    nstate = state;
    nstate = state == S_IDLE ? (accept ? S_EXEC : S_IDLE)
           : state == S_EXEC ? S_RESP
           : (done ? S_IDLE : S_RESP);
  end

  // operand latch, result capture and response handshake
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      last       <= IDXW'(NREQ - 1);
      gidx       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        gidx <= widx;
        op_q <= req_op[4*widx +: 4];
        a_q  <= req_a[32*widx +: 32];
        b_q  <= req_b[32*widx +: 32];
      end
      if (state == S_EXEC) begin
        rsp_result <= sup ? alu_res : '0;
        rsp_zero   <= sup ? alu_res == '0 : 1'b1;
        rsp_err    <= !sup;
        rsp_valid  <= NREQ'(1) << gidx;
      end
      if (done) begin
        rsp_valid <= '0;
        last      <= gidx;
      end
    end
  end
endmodule
